// File: rtl/axi4_frame_reader.sv
// axi4_frame_reader: AXI4 read master that streams a frame buffer out of DDR.
// Fetches the frame as fixed 64-beat bursts into a first-word-fall-through FIFO
// and presents it as a valid/ready word stream tagged with start/end of frame.
//
// Ports
//   clk_100Mhz, rst        clock, synchronous active-high reset
//   enable                 issue bursts while high; the current burst always completes
//   frame_sync             pulse: restart at frame word 0 at the next burst boundary
//   AR*                    AXI4 read address channel (fixed INCR 64 x 8-byte bursts)
//   R*                     AXI4 read data channel
//   m_data/m_valid/m_ready stream output, FIFO head
//   m_sof/m_eof            head word is first/last word of the frame
//   fifo_level             FIFO occupancy
//   rresp_err/rlast_err    sticky AXI error flags
//   state                  FSM state for debug (0 idle, 1 address, 2 data)
module axi4_frame_reader #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter logic [AXI_ADDR_WIDTH-1:0] FRAME_BASE_ADDR = AXI_ADDR_WIDTH'(32'h0100_0000),
    parameter int unsigned BURSTS_PER_FRAME = 300,
    parameter int unsigned FIFO_DEPTH = 128
) (
    input  logic                      clk_100Mhz,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      frame_sync,
    output logic [AXI_ADDR_WIDTH-1:0] ARADDR,
    output logic                      ARVALID,
    input  logic                      ARREADY,
    output logic [7:0]                ARLEN,
    output logic [2:0]                ARSIZE,
    output logic [1:0]                ARBURST,
    output logic [3:0]                ARCACHE,
    output logic [2:0]                ARPROT,
    input  logic [AXI_DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]                RRESP,
    input  logic                      RLAST,
    input  logic                      RVALID,
    output logic                      RREADY,
    output logic [AXI_DATA_WIDTH-1:0] m_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      m_sof,
    output logic                      m_eof,
    output logic [7:0]                fifo_level,
    output logic                      rresp_err,
    output logic                      rlast_err,
    output logic [1:0]                state
);

    localparam int unsigned BEATS       = 64;
    localparam int unsigned BEAT_W      = $clog2(BEATS);
    localparam int unsigned BURST_SHIFT = $clog2(BEATS * AXI_DATA_WIDTH / 8);
    localparam int unsigned IDX_W       = $clog2(BURSTS_PER_FRAME);
    localparam int unsigned PTR_W       = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W       = PTR_W + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    logic [1:0]                state_q;
    logic [1:0]                state_d;
    logic [IDX_W-1:0]          burst_idx_q;
    logic [BEAT_W-1:0]         beat_cnt_q;
    logic                      sync_pend_q;
    logic [AXI_ADDR_WIDTH-1:0] araddr_q;
    logic                      rresp_err_q;
    logic                      rlast_err_q;

    logic [AXI_DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
    logic                      mem_sof  [FIFO_DEPTH];
    logic                      mem_eof  [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_q;
    logic [PTR_W-1:0]          rd_ptr_q;
    logic [LVL_W-1:0]          level_q;

    logic                      sync_eff;
    logic                      credit_ok;
    logic                      start_burst;
    logic                      beat_hs;
    logic                      last_beat;
    logic                      push;
    logic                      pop;
    logic                      push_sof;
    logic                      push_eof;
    logic [IDX_W-1:0]          start_idx;
    logic [AXI_ADDR_WIDTH-1:0] burst_addr;

    // Fixed burst shape: 64 beats of 8 bytes, INCR, cacheable, non-secure data access.
    assign ARLEN   = 8'(BEATS - 1);
    assign ARSIZE  = 3'b011;
    assign ARBURST = 2'b01;
    assign ARCACHE = 4'b1111;
    assign ARPROT  = 3'b010;

    assign ARADDR  = araddr_q;
    assign ARVALID = (state_q == ST_ADDR);
    assign RREADY  = (state_q == ST_DATA);
    assign state   = state_q;

    // A sync arriving while idle takes effect for the very next burst.
    assign sync_eff    = sync_pend_q | frame_sync;
    // Room for a whole burst is reserved up front, so RREADY never has to drop.
    assign credit_ok   = (level_q <= LVL_W'(FIFO_DEPTH - BEATS));
    assign start_burst = (state_q == ST_IDLE) && enable && credit_ok;
    assign beat_hs     = (state_q == ST_DATA) && RVALID;
    assign last_beat   = (beat_cnt_q == BEAT_W'(BEATS - 1));
    assign start_idx   = sync_eff ? '0 : burst_idx_q;
    assign burst_addr  = FRAME_BASE_ADDR + (AXI_ADDR_WIDTH'(start_idx) << BURST_SHIFT);

    assign push     = beat_hs;
    assign pop      = m_valid && m_ready;
    assign push_sof = (burst_idx_q == '0) && (beat_cnt_q == '0);
    assign push_eof = (burst_idx_q == IDX_W'(BURSTS_PER_FRAME - 1)) && last_beat;

    // State register.
    always_ff @(posedge clk_100Mhz) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_burst)           state_d = ST_ADDR;
            ST_ADDR: if (ARREADY)               state_d = ST_DATA;
            ST_DATA: if (beat_hs && last_beat)  state_d = ST_IDLE;
            default:                            state_d = ST_IDLE;
        endcase
    end

    // Burst/beat counters, address register, frame sync and sticky errors.
    always_ff @(posedge clk_100Mhz) begin
        if (rst) begin
            burst_idx_q <= '0;
            beat_cnt_q  <= '0;
            sync_pend_q <= 1'b0;
            araddr_q    <= FRAME_BASE_ADDR;
            rresp_err_q <= 1'b0;
            rlast_err_q <= 1'b0;
        end else begin
            if (frame_sync) begin
                sync_pend_q <= 1'b1;
            end
            if (state_q == ST_IDLE) begin
                if (sync_eff) begin
                    burst_idx_q <= '0;
                    sync_pend_q <= 1'b0;
                end
                if (start_burst) begin
                    araddr_q <= burst_addr;
                end
            end
            if (beat_hs) begin
                beat_cnt_q <= last_beat ? '0 : beat_cnt_q + BEAT_W'(1);
                if (RRESP != 2'b00) begin
                    rresp_err_q <= 1'b1;
                end
                // Burst length is counted; RLAST is only cross-checked.
                if (RLAST != last_beat) begin
                    rlast_err_q <= 1'b1;
                end
                if (last_beat) begin
                    burst_idx_q <= (burst_idx_q == IDX_W'(BURSTS_PER_FRAME - 1)) ?
                                   '0 : burst_idx_q + IDX_W'(1);
                end
            end
        end
    end

    assign rresp_err = rresp_err_q;
    assign rlast_err = rlast_err_q;

    // FIFO storage, not reset: validity is tracked by level_q.
    always_ff @(posedge clk_100Mhz) begin
        if (push) begin
            mem_data[wr_ptr_q] <= RDATA;
            mem_sof[wr_ptr_q]  <= push_sof;
            mem_eof[wr_ptr_q]  <= push_eof;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_100Mhz) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    assign m_valid    = (level_q != '0);
    assign m_data     = mem_data[rd_ptr_q];
    assign m_sof      = mem_sof[rd_ptr_q];
    assign m_eof      = mem_eof[rd_ptr_q];
    assign fifo_level = 8'(level_q);

endmodule
